// File: rtl/sha256_round_engine.sv
`default_nettype none
// ============================================================================
// Module   : sha256_round_engine
// Purpose  : SHA-256 compression of one 512-bit block, one round per cycle,
//            fed W[t] by an external message scheduler.
// Revision : 1.0
// ============================================================================
module sha256_round_engine #(
   parameter int MSG_BLK  = 32,
   parameter int BLK_CNT  = 6,
   parameter int DGST_SIZ = 256
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                i_start,
   input  logic                i_init,
   output logic                o_msg_schdl_en,
   output logic [BLK_CNT-1:0]  o_blk_nmbr,
   input  logic [MSG_BLK-1:0]  i_msg_blk,
   output logic                o_busy,
   output logic                o_done,
   output logic [DGST_SIZ-1:0] o_digest
);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_fetch = 2'd1;
   localparam logic [1:0] c_st_round = 2'd2;
   localparam logic [1:0] c_st_final = 2'd3;

   localparam logic [DGST_SIZ-1:0] c_iv =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   localparam logic [MSG_BLK-1:0] c_k [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [MSG_BLK-1:0] f_rotr(input logic [MSG_BLK-1:0] x, input int n);
      return (x >> n) | (x << (MSG_BLK - n));
   endfunction

   logic [1:0]          r_state;
   logic [BLK_CNT-1:0]  r_t;
   logic [BLK_CNT-1:0]  r_idx;
   logic                r_en;
   logic                r_busy;
   logic                r_done;
   logic [DGST_SIZ-1:0] r_hash;
   logic [DGST_SIZ-1:0] r_digest;
   logic [MSG_BLK-1:0]  r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;

   logic [MSG_BLK-1:0]  w_sig0, w_sig1, w_ch, w_maj, w_t1, w_t2;
   logic [DGST_SIZ-1:0] w_chain;
   logic [DGST_SIZ-1:0] w_work;
   logic [DGST_SIZ-1:0] w_final;

   always_comb begin
      w_sig0 = f_rotr(r_a, 2) ^ f_rotr(r_a, 13) ^ f_rotr(r_a, 22);
      w_sig1 = f_rotr(r_e, 6) ^ f_rotr(r_e, 11) ^ f_rotr(r_e, 25);
      w_ch   = (r_e & r_f) ^ (~r_e & r_g);
      w_maj  = (r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c);
      w_t1   = r_h + w_sig1 + w_ch + c_k[r_t] + i_msg_blk;
      w_t2   = w_sig0 + w_maj;
   end

   assign w_chain = i_init ? c_iv : r_digest;
   assign w_work  = {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h};

   for (genvar gi = 0; gi < 8; gi++) begin : g_final
      assign w_final[DGST_SIZ-1-MSG_BLK*gi -: MSG_BLK] =
         r_hash[DGST_SIZ-1-MSG_BLK*gi -: MSG_BLK] + w_work[DGST_SIZ-1-MSG_BLK*gi -: MSG_BLK];
   end

   // The scheduler returns W[t] one cycle after the index, so the index runs two ahead of t.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= c_st_idle;
         r_t      <= '0;
         r_idx    <= '0;
         r_en     <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hash   <= '0;
         r_digest <= '0;
         {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            c_st_idle: begin
               if (i_start) begin
                  {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= w_chain;
                  r_hash  <= w_chain;
                  r_idx   <= '0;
                  r_en    <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= c_st_fetch;
               end
            end
            c_st_fetch: begin
               r_idx   <= BLK_CNT'(1);
               r_t     <= '0;
               r_state <= c_st_round;
            end
            c_st_round: begin
               r_h <= r_g;
               r_g <= r_f;
               r_f <= r_e;
               r_e <= r_d + w_t1;
               r_d <= r_c;
               r_c <= r_b;
               r_b <= r_a;
               r_a <= w_t1 + w_t2;
               r_t <= r_t + BLK_CNT'(1);
               if (r_t <= BLK_CNT'(61)) begin
                  r_idx <= r_t + BLK_CNT'(2);
               end else begin
                  r_en <= 1'b0;
               end
               if (r_t == BLK_CNT'(63)) begin
                  r_state <= c_st_final;
               end
            end
            c_st_final: begin
               r_digest <= w_final;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= c_st_idle;
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   assign o_msg_schdl_en = r_en;
   assign o_blk_nmbr     = r_idx;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_digest       = r_digest;

endmodule
`default_nettype wire

// File: doc/sha256_round_engine.md
# sha256_round_engine

SHA-256 compression engine that consumes the per-round words of the message scheduler. It drives the scheduler's enable and word-index inputs and reads back one 32-bit W[t] per cycle. It runs the 64 FIPS 180-4 rounds and adds the result into the chaining hash to produce a 256-bit digest. It sits between the block sequencer (which supplies `i_msg` to the scheduler and pulses start) and the digest output register.

## Interface
- `MSG_BLK`, 32, word width of W[t] and of the working variables a..h
- `BLK_CNT`, 6, width of the word-index bus (0..63)
- `DGST_SIZ`, 256, digest width
- `clk` input 1: clock
- `reset_n` input 1: asynchronous, active-low reset
- `i_start` input 1: begin compressing one 512-bit block; sampled only in IDLE
- `i_init` input 1: sampled with `i_start`; 1 = first block (chain from IV), 0 = continuation (chain from current `o_digest`)
- `o_msg_schdl_en` output 1: enable to scheduler, registered
- `o_blk_nmbr` output BLK_CNT: word index t to scheduler, registered
- `i_msg_blk` input MSG_BLK: W[t] from scheduler; valid one cycle after the index is issued
- `o_busy` output 1: block in progress
- `o_done` output 1: one-cycle pulse when `o_digest` is updated
- `o_digest` output DGST_SIZ: H0 in [255:224] … H7 in [31:0]

## Operation
- States: IDLE, FETCH, ROUND, FINAL.
- IDLE with `i_start`=1:
  - Load a..h from IV if `i_init`=1. IV = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - Otherwise load a..h from `o_digest`.
  - Latch the chaining value into internal H.
  - Issue index 0 with enable=1. Go to FETCH.
- FETCH: issue index 1, clear round counter t=0. Go to ROUND.
- ROUND, one round per cycle using `i_msg_blk` as W[t] and constant K[t]:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]
  - T2 = Σ0(a) + Maj(a,b,c)
  - h..a ← g, f, e, d+T1, c, b, a, T1+T2
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25.
  - Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
  - All additions are modulo 2^32; carries are discarded.
  - K[0..63] is the standard FIPS 180-4 table, held in a constant ROM indexed by t.
  - Next index = t+2 while t+2 ≤ 63.
  - Enable deasserts on the edge after index 63 is issued. The index is not incremented past 63 (no wrap to 0).
  - After t=63, go to FINAL.
- FINAL: `o_digest` ← {H0+a, …, H7+h} (each mod 2^32). Pulse `o_done`. Go to IDLE.
- Upstream holds the scheduler's `i_msg` stable from `i_start` until `o_done`.
- `i_start` outside IDLE is ignored; no queuing.
- `i_init` is ignored unless sampled with an accepted `i_start`.

## Timing
- Reset values:
  - State = IDLE.
  - `o_msg_schdl_en`=0, `o_blk_nmbr`=0, `o_busy`=0, `o_done`=0.
  - `o_digest`=0; a..h=0.
- Edge numbering, E0 = the edge that accepts `i_start`:
  - E0: index 0 issued, enable high.
  - E1: index 1 issued.
  - Ek: index k issued, for k ≤ 63.
  - E64: enable low.
  - Round t completes at E(t+2), so round 63 completes at E65.
  - E66: `o_digest` updated and `o_done` high for exactly one cycle.
- Latency from start acceptance to done = 66 cycles.
- `o_busy` is high from after E0 until E66, where it falls in the same cycle `o_done` rises.
- The earliest next start is accepted at E67 (back-to-back throughput = 67 cycles per block).
- `o_digest` holds its value between blocks and changes only at FINAL or reset.
- Reset asserted mid-block: all outputs return to reset values immediately. The partially computed state is discarded, and `o_digest` becomes 0. A following block with `i_init`=0 therefore chains from 0. The sequencer must restart with `i_init`=1.

## Test plan
- Pulse reset: all outputs 0. Hold `i_start` low for 20 cycles: no output changes and enable stays 0.
- Padded "abc" block (61626380 00…00 00000018), `i_init`=1:
  - `o_done` rises 66 cycles after start.
  - `o_digest` = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
  - Indices 0..63 are issued on consecutive edges.
- Empty-message block (80000000 00…00), `i_init`=1 → e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Block 1 with `i_init`=1, block 2 with `i_init`=0, started back-to-back at E67.
  - Final digest = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- Pulse `i_start` at cycles 10 and 40 of a block in progress: ignored, with a single `o_done` at cycle 66 and a correct digest. Assert reset at round 30: outputs clear at once, and a fresh "abc" run afterwards gives the correct digest.
